// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle fetch/decode/execute/memory/writeback sequencer.
// Owns the instruction register and the latched immediate, and drives the
// memory handshake, PC update select and register-file write enable.
module ctrl_fsm #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter logic [31:0] RESET_IR    = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ir,
    input  logic [31:0] imm_in,
    output logic [31:0] imm_q,
    input  logic        branch_taken,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        halted,
    output logic        illegal,
    output logic        bus_err,
    output logic [3:0]  state_o
);

    typedef enum logic [3:0] {
        S_BOOT       = 4'd0,
        S_FETCH      = 4'd1,
        S_FETCH_WAIT = 4'd2,
        S_DECODE     = 4'd3,
        S_EXECUTE    = 4'd4,
        S_MEM        = 4'd5,
        S_MEM_WAIT   = 4'd6,
        S_WRITEBACK  = 4'd7,
        S_HALT       = 4'd8,
        S_TRAP       = 4'd9
    } state_t;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam int unsigned CW = $clog2(MEM_TIMEOUT + 2);
    localparam logic [CW-1:0] TO_LAST = CW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    state_t          state;
    logic [CW-1:0]   to_cnt;
    logic [6:0]      opc;
    logic            mem_state;
    logic            handshake;
    logic            timeout_hit;

    assign opc     = ir[6:0];
    assign state_o = state;

    // Handshake / timeout qualifiers for the four memory-facing states
    always_comb begin
        mem_state = (state == S_FETCH) || (state == S_FETCH_WAIT) ||
                    (state == S_MEM)   || (state == S_MEM_WAIT);
        handshake = (((state == S_FETCH) || (state == S_MEM)) && mem_gnt) ||
                    (((state == S_FETCH_WAIT) || (state == S_MEM_WAIT)) && mem_rvalid);
        // Fires on the cycle the counter would reach MEM_TIMEOUT; handshake takes priority
        timeout_hit = (MEM_TIMEOUT != 0) && mem_state && (to_cnt == TO_LAST);
    end

    // Sequencer state, instruction/immediate registers, timeout counter, sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_BOOT;
            ir      <= RESET_IR;
            imm_q   <= '0;
            to_cnt  <= '0;
            halted  <= 1'b0;
            illegal <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            if (mem_state && !handshake && !timeout_hit && (MEM_TIMEOUT != 0))
                to_cnt <= to_cnt + CW'(1);
            else
                to_cnt <= '0;

            case (state)
                S_BOOT: state <= S_FETCH;
                S_FETCH: begin
                    if (mem_gnt) state <= S_FETCH_WAIT;
                    else if (timeout_hit) begin
                        state   <= S_TRAP;
                        bus_err <= 1'b1;
                    end
                end
                S_FETCH_WAIT: begin
                    if (mem_rvalid) begin
                        ir    <= mem_rdata;
                        state <= S_DECODE;
                    end else if (timeout_hit) begin
                        state   <= S_TRAP;
                        bus_err <= 1'b1;
                    end
                end
                S_DECODE: begin
                    imm_q <= imm_in;
                    case (opc)
                        OP_OP, OP_IMM, OP_LUI, OP_AUIPC, OP_LOAD, OP_STORE,
                        OP_BRANCH, OP_JAL, OP_JALR, OP_FENCE: state <= S_EXECUTE;
                        OP_SYSTEM: begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end
                        default: begin
                            state   <= S_TRAP;
                            illegal <= 1'b1;
                        end
                    endcase
                end
                S_EXECUTE: begin
                    case (opc)
                        OP_LOAD, OP_STORE:   state <= S_MEM;
                        OP_BRANCH, OP_FENCE: state <= S_FETCH;
                        default:             state <= S_WRITEBACK;
                    endcase
                end
                S_MEM: begin
                    if (mem_gnt) state <= S_MEM_WAIT;
                    else if (timeout_hit) begin
                        state   <= S_TRAP;
                        bus_err <= 1'b1;
                    end
                end
                S_MEM_WAIT: begin
                    if (mem_rvalid)
                        state <= (opc == OP_STORE) ? S_FETCH : S_WRITEBACK;
                    else if (timeout_hit) begin
                        state   <= S_TRAP;
                        bus_err <= 1'b1;
                    end
                end
                S_WRITEBACK: state <= S_FETCH;
                default:     state <= state;
            endcase
        end
    end

    // Control outputs decoded from registered state and opcode; the branch
    // select and store-ack PC strobe also look at their same-cycle qualifier
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 2'b00;
        rf_we        = 1'b0;
        wb_sel       = 2'b00;
        case (state)
            S_FETCH: mem_req = 1'b1;
            S_EXECUTE: begin
                if (opc == OP_BRANCH) begin
                    pc_we  = 1'b1;
                    pc_src = branch_taken ? 2'b10 : 2'b00;
                end else if (opc == OP_FENCE) begin
                    pc_we = 1'b1;
                end
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (opc == OP_STORE);
            end
            S_MEM_WAIT: pc_we = (opc == OP_STORE) && mem_rvalid;
            S_WRITEBACK: begin
                rf_we = 1'b1;
                pc_we = 1'b1;
                case (opc)
                    OP_JAL: begin
                        wb_sel = 2'b10;
                        pc_src = 2'b10;
                    end
                    OP_JALR: begin
                        wb_sel = 2'b10;
                        pc_src = 2'b01;
                    end
                    OP_LUI:  wb_sel = 2'b11;
                    OP_LOAD: wb_sel = 2'b01;
                    default: wb_sel = 2'b00;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ctrl_fsm.sv
// tb_ctrl_fsm: directed vectors for the control sequencer with hand-computed
// expectations; MEM_TIMEOUT is set to 4 so bus-error timing is short.
module tb_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req, mem_we, mem_addr_sel;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata, ir, imm_in, imm_q;
    logic        branch_taken;
    logic        pc_we, rf_we, halted, illegal, bus_err;
    logic [1:0]  pc_src, wb_sel;
    logic [3:0]  state_o;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    ctrl_fsm #(.MEM_TIMEOUT(4), .RESET_IR(32'h0000_0013)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .ir(ir), .imm_in(imm_in), .imm_q(imm_q), .branch_taken(branch_taken),
        .pc_we(pc_we), .pc_src(pc_src), .rf_we(rf_we), .wb_sel(wb_sel),
        .halted(halted), .illegal(illegal), .bus_err(bus_err), .state_o(state_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] outs();
        return {mem_req, mem_we, mem_addr_sel, pc_we, pc_src, rf_we, wb_sel,
                halted, illegal, bus_err};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // Starts at a negedge in FETCH; zero-wait fetch + decode; ends one cycle past DECODE
    task automatic do_fetch(input logic [31:0] instr, input logic [31:0] imm);
        mem_gnt = 1'b1; #1;
        check("fetch_state", 32'(state_o), 32'd1);
        check("fetch_req", 32'(mem_req), 32'd1);
        check("fetch_sel_we", 32'({mem_addr_sel, mem_we}), 32'd0);
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = instr; #1;
        check("fwait_state", 32'(state_o), 32'd2);
        check("fwait_req", 32'(mem_req), 32'd0);
        tick();
        mem_rvalid = 1'b0; imm_in = imm; #1;
        check("decode_state", 32'(state_o), 32'd3);
        check("decode_ir", ir, instr);
        tick(); #1;
        check("imm_q", imm_q, imm);
    endtask

    // Runs EXECUTE -> WRITEBACK for a register-writing instruction and checks the WB strobes
    task automatic do_wb(input string tag, input logic [1:0] wb, input logic [1:0] src);
        check({tag, "_exec_state"}, 32'(state_o), 32'd4);
        check({tag, "_exec_we"}, 32'({pc_we, rf_we}), 32'd0);
        tick(); #1;
        check({tag, "_wb_state"}, 32'(state_o), 32'd7);
        check({tag, "_wb_strobes"}, 32'({rf_we, pc_we}), 32'b11);
        check({tag, "_wb_sel"}, 32'(wb_sel), 32'(wb));
        check({tag, "_pc_src"}, 32'(pc_src), 32'(src));
        tick(); #1;
        check({tag, "_back_fetch"}, 32'(state_o), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        imm_in = '0; branch_taken = 1'b0;
        #12;
        check("rst_outs", 32'(outs()), 32'd0);
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_ir", ir, 32'h0000_0013);
        check("rst_imm_q", imm_q, 32'd0);
        tick(); rst_n = 1'b1; #1;
        check("boot_state", 32'(state_o), 32'd0);
        tick(); #1;

        // ADDI x1,x0,5: WB in cycle 5 with wb_sel=00, pc_src=00
        do_fetch(32'h0050_0093, 32'd5);
        do_wb("addi", 2'b00, 2'b00);

        // BEQ taken, imm=-8
        do_fetch(32'hFE00_0CE3, 32'hFFFF_FFF8);
        branch_taken = 1'b1; #1;
        check("beq_state", 32'(state_o), 32'd4);
        check("beq_pc_we", 32'(pc_we), 32'd1);
        check("beq_pc_src", 32'(pc_src), 32'd2);
        check("beq_rf_we", 32'(rf_we), 32'd0);
        tick(); branch_taken = 1'b0; #1;
        check("beq_fetch", 32'(state_o), 32'd1);

        // BNE not taken, imm=8
        do_fetch(32'h0020_9463, 32'd8);
        check("bne_pc", 32'({pc_we, pc_src}), 32'b100);
        tick(); #1;
        check("bne_fetch", 32'(state_o), 32'd1);

        // JAL x1,8 and LUI x1,0x12345
        do_fetch(32'h0080_00EF, 32'd8);
        do_wb("jal", 2'b10, 2'b10);
        do_fetch(32'h1234_50B7, 32'h1234_5000);
        do_wb("lui", 2'b11, 2'b00);

        // LW with grant withheld 3 cycles; grant on the counter's last cycle still wins
        do_fetch(32'h0041_2083, 32'd4);
        check("lw_exec_pc_we", 32'(pc_we), 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            check("lw_mem_hold", 32'({state_o, mem_req, mem_addr_sel, mem_we}), 32'b0101_110);
            tick();
        end
        mem_gnt = 1'b1; #1;
        check("lw_mem_gnt", 32'({state_o, mem_req, mem_addr_sel, mem_we}), 32'b0101_110);
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; #1;
        check("lw_mwait", 32'({state_o, mem_req, pc_we}), 32'b0110_00);
        tick(); mem_rvalid = 1'b0; #1;
        check("lw_wb_state", 32'(state_o), 32'd7);
        check("lw_wb", 32'({rf_we, pc_we, wb_sel, pc_src}), 32'b11_01_00);
        check("lw_ir_kept", ir, 32'h0041_2083);
        tick(); #1;
        check("lw_fetch", 32'(state_o), 32'd1);

        // SW: store access, ack after one wait cycle
        do_fetch(32'h0011_2223, 32'd4);
        tick(); mem_gnt = 1'b1; #1;
        check("sw_mem", 32'({state_o, mem_req, mem_addr_sel, mem_we}), 32'b0101_111);
        tick(); mem_gnt = 1'b0; #1;
        check("sw_wait_nopc", 32'({state_o, pc_we}), 32'b0110_0);
        tick(); mem_rvalid = 1'b1; #1;
        check("sw_ack", 32'({pc_we, pc_src, rf_we}), 32'b1000);
        tick(); mem_rvalid = 1'b0; #1;
        check("sw_fetch", 32'(state_o), 32'd1);
        check("sw_no_bus_err", 32'(bus_err), 32'd0);

        // Illegal opcode: sticky TRAP, grants ignored, cleared by reset pulse
        do_fetch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        mem_gnt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("ill_trap", 32'({state_o, illegal, mem_req, pc_we, rf_we}), 32'b1001_1000);
            tick();
        end
        mem_gnt = 1'b0; rst_n = 1'b0; #1;
        check("ill_rst_outs", 32'(outs()), 32'd0);
        check("ill_rst_ir", ir, 32'h0000_0013);
        tick(); rst_n = 1'b1;
        tick(); #1;

        // Fetch response withheld: bus error after 4 FETCH_WAIT cycles
        mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("to_wait", 32'({state_o, bus_err}), 32'b0010_0);
            tick();
        end
        #1;
        check("to_trap", 32'({state_o, bus_err, illegal, mem_req}), 32'b1001_100);
        rst_n = 1'b0; #1;
        check("to_rst_outs", 32'(outs()), 32'd0);
        tick(); rst_n = 1'b1;
        tick(); #1;

        // rvalid on the last allowed FETCH_WAIT cycle wins over the timeout
        mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
        tick(); tick(); tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h0050_0093;
        tick(); mem_rvalid = 1'b0; #1;
        check("to_edge_decode", 32'({state_o, bus_err}), 32'b0011_0);
        tick(); tick(); tick(); #1;
        check("to_edge_fetch", 32'(state_o), 32'd1);

        // Reset asserted mid-wait with a response in flight
        mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
        tick(); mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; #1;
        rst_n = 1'b0; #1;
        check("mid_rst_outs", 32'(outs()), 32'd0);
        check("mid_rst_state", 32'(state_o), 32'd0);
        check("mid_rst_ir", ir, 32'h0000_0013);
        tick(); rst_n = 1'b1; mem_rvalid = 1'b0;
        tick(); #1;
        check("mid_rst_fetch", 32'(state_o), 32'd1);
        check("mid_rst_discard", ir, 32'h0000_0013);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
